// File: rtl/vrf_lane_addr_gen.sv
// Per-lane VRF access sequencer: one vector-register request in, one bank/address/strobe beat per cycle out.
// Optional macro VRF_BANK_SWIZZLE_EN offsets the bank id by the base register to spread operands across banks.
module vrf_lane_addr_gen #(
  parameter int unsigned NrLane        = 2,
  parameter int unsigned LaneId        = 0,
  parameter int unsigned VLEN          = 1024,
  parameter int unsigned VRFWordWidth  = 64,
  parameter int unsigned NrBank        = 8,
  parameter int unsigned VLWidth       = $clog2(VLEN + 1),
  parameter int unsigned VRFWordWidthB = VRFWordWidth / 8,
  parameter int unsigned BankW         = $clog2(NrBank),
  parameter int unsigned BankAddrW     = $clog2(VLEN * 32 / NrLane / VRFWordWidth / NrBank)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [4:0]               req_vreg_i,
  input  logic [1:0]               req_vew_i,
  input  logic [VLWidth-1:0]       req_vl_i,
  input  logic [VLWidth-1:0]       req_vstart_i,
  output logic                     addr_valid_o,
  input  logic                     addr_ready_i,
  output logic [BankW-1:0]         addr_bank_o,
  output logic [BankAddrW-1:0]     addr_bank_addr_o,
  output logic [VRFWordWidthB-1:0] addr_strb_o,
  output logic                     addr_last_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int unsigned LaneShift = $clog2(NrLane);
  localparam int unsigned SumW      = VLWidth + 1;
  localparam int unsigned ByteW     = SumW + 3;
  localparam int unsigned OffW      = $clog2(VRFWordWidthB);
  localparam int unsigned WordIdxW  = ByteW - OffW;
  localparam int unsigned RegShift  = $clog2(VLEN / NrLane / VRFWordWidth);
  localparam int unsigned WordAddrW = BankW + BankAddrW;
  localparam logic [VRFWordWidthB-1:0] AllOnes = '1;

  typedef enum logic [1:0] {IDLE, GEN, EMPTY} state_e;

  state_e                   state_q, state_d;
  logic                     req_ready_q, req_ready_d;
  logic                     busy_q, busy_d;
  logic                     addr_valid_q, addr_valid_d;
  logic [BankW-1:0]         bank_q, bank_d;
  logic [BankAddrW-1:0]     bank_addr_q, bank_addr_d;
  logic [VRFWordWidthB-1:0] strb_q, strb_d;
  logic                     last_q, last_d;
  logic [WordIdxW-1:0]      word_q, word_d;
  logic [WordIdxW-1:0]      last_word_q, last_word_d;
  logic [4:0]               vreg_q, vreg_d;
  logic [OffW-1:0]          eofs_q, eofs_d;

  logic [SumW-1:0]          lane_vstart_c, lane_vl_c;
  logic [ByteW-1:0]         start_byte_c, end_byte_c, end_m1_c;
  logic                     empty_c;
  logic [WordIdxW-1:0]      first_word_c, last_word_c;

  logic [WordIdxW-1:0]      beat_word_c;
  logic [4:0]               beat_vreg_c;
  logic                     beat_first_c, beat_last_c;
  logic [OffW-1:0]          beat_sofs_c, beat_eofs_c;
  logic [WordAddrW-1:0]     beat_waddr_c;
  logic [BankW-1:0]         beat_bank_c;
  logic [BankAddrW-1:0]     beat_bank_addr_c;
  logic [VRFWordWidthB-1:0] beat_strb_c;

  // Share of the request owned by this lane, as a byte range within the lane's register slice
  always_comb begin
    lane_vstart_c = (SumW'(req_vstart_i) + SumW'(NrLane - 1 - LaneId)) >> LaneShift;
    lane_vl_c     = (SumW'(req_vl_i) + SumW'(NrLane - 1 - LaneId)) >> LaneShift;
    empty_c       = lane_vstart_c >= lane_vl_c;
    start_byte_c  = ByteW'(lane_vstart_c) << req_vew_i;
    end_byte_c    = ByteW'(lane_vl_c) << req_vew_i;
    end_m1_c      = end_byte_c - ByteW'(1);
    first_word_c  = start_byte_c[ByteW-1:OffW];
    last_word_c   = end_m1_c[ByteW-1:OffW];
  end

  // Next beat to present: the first word on acceptance, otherwise the word after the current one
  always_comb begin
    if (state_q == IDLE) begin
      beat_word_c  = first_word_c;
      beat_vreg_c  = req_vreg_i;
      beat_first_c = 1'b1;
      beat_sofs_c  = start_byte_c[OffW-1:0];
      beat_last_c  = (first_word_c == last_word_c);
      beat_eofs_c  = end_m1_c[OffW-1:0];
    end else begin
      beat_word_c  = word_q + WordIdxW'(1);
      beat_vreg_c  = vreg_q;
      beat_first_c = 1'b0;
      beat_sofs_c  = '0;
      beat_last_c  = (beat_word_c == last_word_q);
      beat_eofs_c  = eofs_q;
    end
    // Truncation to WordAddrW bits wraps register groups past v31 around the slice
    beat_waddr_c     = (WordAddrW'(beat_vreg_c) << RegShift) + WordAddrW'(beat_word_c);
    beat_bank_addr_c = beat_waddr_c[WordAddrW-1:BankW];
`ifdef VRF_BANK_SWIZZLE_EN
    beat_bank_c      = beat_waddr_c[BankW-1:0] + BankW'(beat_vreg_c);
`else
    beat_bank_c      = beat_waddr_c[BankW-1:0];
`endif
    beat_strb_c = AllOnes;
    if (beat_first_c) beat_strb_c = beat_strb_c & (AllOnes << beat_sofs_c);
    if (beat_last_c)  beat_strb_c = beat_strb_c & (AllOnes >> (OffW'(VRFWordWidthB - 1) - beat_eofs_c));
  end

  // Next-state and registered outputs
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    addr_valid_d = addr_valid_q;
    bank_d       = bank_q;
    bank_addr_d  = bank_addr_q;
    strb_d       = strb_q;
    last_d       = last_q;
    word_d       = word_q;
    last_word_d  = last_word_q;
    vreg_d       = vreg_q;
    eofs_d       = eofs_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_ready_d = 1'b0;
          if (empty_c) begin
            state_d = EMPTY;
          end else begin
            state_d      = GEN;
            busy_d       = 1'b1;
            word_d       = first_word_c;
            last_word_d  = last_word_c;
            vreg_d       = req_vreg_i;
            eofs_d       = end_m1_c[OffW-1:0];
            addr_valid_d = 1'b1;
            bank_d       = beat_bank_c;
            bank_addr_d  = beat_bank_addr_c;
            strb_d       = beat_strb_c;
            last_d       = beat_last_c;
          end
        end
      end
      GEN: begin
        if (addr_ready_i) begin
          if (last_q) begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            busy_d       = 1'b0;
            addr_valid_d = 1'b0;
            last_d       = 1'b0;
          end else begin
            word_d      = beat_word_c;
            bank_d      = beat_bank_c;
            bank_addr_d = beat_bank_addr_c;
            strb_d      = beat_strb_c;
            last_d      = beat_last_c;
          end
        end
      end
      EMPTY: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      bank_q       <= '0;
      bank_addr_q  <= '0;
      strb_q       <= '0;
      last_q       <= 1'b0;
      word_q       <= '0;
      last_word_q  <= '0;
      vreg_q       <= '0;
      eofs_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      addr_valid_q <= addr_valid_d;
      bank_q       <= bank_d;
      bank_addr_q  <= bank_addr_d;
      strb_q       <= strb_d;
      last_q       <= last_d;
      word_q       <= word_d;
      last_word_q  <= last_word_d;
      vreg_q       <= vreg_d;
      eofs_q       <= eofs_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign busy_o           = busy_q;
  assign addr_valid_o     = addr_valid_q;
  assign addr_bank_o      = bank_q;
  assign addr_bank_addr_o = bank_addr_q;
  assign addr_strb_o      = strb_q;
  assign addr_last_o      = last_q;
  // Completion coincides with the last-beat handshake, so it cannot wait for a register stage
  assign done_o = (state_q == EMPTY) | (addr_valid_q & addr_ready_i & last_q);

endmodule
